// File: rtl/clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// clk_rst_sequencer: CHANNELS programmable clock dividers / strobes with a
// staggered, edge-aligned per-channel reset release and a locked flag.
// Optional macro CLKRST_DEBOUNCE_EN filters the reset release.
// Revision: 1.0
// ============================================================================
module clk_rst_sequencer #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 16,
  parameter int DELAY_BIT    = 15,
  parameter int STAGGER_BIT  = 10,
  parameter int DEBOUNCE_BIT = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS-1:0]       mode_in,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       rst_out,
  output logic                      locked
);

  localparam int DLY_A = DELAY_BIT;
  localparam int DLY_B = STAGGER_BIT + $clog2(CHANNELS);
  localparam int DLY_W = ((DLY_A > DLY_B) ? DLY_A : DLY_B) + 2;
  localparam logic [DLY_W-1:0] BASE_HOLD = DLY_W'(1) << DELAY_BIT;
  localparam logic [DLY_W-1:0] STAG_HOLD = DLY_W'(1) << STAGGER_BIT;
  localparam logic [DLY_W-1:0] DLY_MAX   = BASE_HOLD + DLY_W'(CHANNELS - 1) * STAG_HOLD;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  logic [DLY_W-1:0]    dly;
  logic [DLY_W-1:0]    dly_next;
  logic [CNT_W-1:0]    cnt  [CHANNELS];
  logic [CNT_W-1:0]    dval [CHANNELS];
  logic [CHANNELS-1:0] mode_q;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] lvl_next;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] elig;
  logic                filt_done;
  logic                div_hold;

`ifdef CLKRST_DEBOUNCE_EN
  logic [DEBOUNCE_BIT-1:0] filt;
  assign filt_done = &filt;
  // Dividers stay in their reset state until the release filter completes.
  assign div_hold  = reset | ((state == HOLD) & ~filt_done);
`else
  logic [DEBOUNCE_BIT:0] unused_filt;
  assign unused_filt = '0;
  assign filt_done   = 1'b1;
  assign div_hold    = reset;
`endif

  always_comb begin
    dly_next = (dly < DLY_MAX) ? dly + 1'b1 : dly;
    evt      = '0;
    lvl_next = '0;
    qual     = '0;
    elig     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      evt[k]      = (cnt[k] == dval[k]);
      // Strobe, or toggle restarting after strobe, both produce a high level.
      lvl_next[k] = (mode_in[k] | mode_q[k]) ? 1'b1 : ~clk_out[k];
      qual[k]     = evt[k] & (mode_in[k] | (clk_out[k] & ~lvl_next[k]));
      elig[k]     = (dly_next >= BASE_HOLD + DLY_W'(k) * STAG_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (div_hold) begin
        cnt[k]     <= '0;
        dval[k]    <= div_in[k*CNT_W +: CNT_W];
        mode_q[k]  <= mode_in[k];
        clk_out[k] <= 1'b0;
      end else if (evt[k]) begin
        cnt[k]     <= '0;
        dval[k]    <= div_in[k*CNT_W +: CNT_W];
        mode_q[k]  <= mode_in[k];
        clk_out[k] <= lvl_next[k];
      end else begin
        cnt[k] <= cnt[k] + 1'b1;
        if (mode_q[k]) clk_out[k] <= 1'b0;
      end
    end

    if (reset) begin
      state   <= HOLD;
      dly     <= '0;
      rst_out <= '1;
      locked  <= 1'b0;
`ifdef CLKRST_DEBOUNCE_EN
      filt    <= '0;
`endif
    end else begin
      case (state)
        HOLD: begin
          if (filt_done) begin
            state <= COUNT;
            dly   <= '0;
          end
`ifdef CLKRST_DEBOUNCE_EN
          else filt <= filt + 1'b1;
`endif
        end
        COUNT: begin
          dly <= dly_next;
          for (int k = 0; k < CHANNELS; k++) begin
            if (qual[k] & elig[k]) rst_out[k] <= 1'b0;
          end
          if (rst_out == '0) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
`default_nettype none
// tb_clk_rst_sequencer: event-schedule reference model checked every cycle,
// plus hand-computed timing expectations for each directed scenario.
module tb_clk_rst_sequencer;

  localparam int CH = 2;
  localparam int CW = 8;
  localparam int DB = 4;
  localparam int SB = 3;
  localparam int FB = 3;
`ifdef CLKRST_DEBOUNCE_EN
  localparam int FILT = 1 << FB;
`else
  localparam int FILT = 1;
`endif
  localparam int SH = FILT - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [CH*CW-1:0] div_in = '0;
  logic [CH-1:0]  mode_in = '0;
  logic [CH-1:0]  clk_out;
  logic [CH-1:0]  rst_out;
  logic           locked;

  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .CHANNELS(CH), .CNT_W(CW), .DELAY_BIT(DB), .STAGGER_BIT(SB), .DEBOUNCE_BIT(FB)
  ) dut (
    .clk(clk), .reset(reset), .div_in(div_in), .mode_in(mode_in),
    .clk_out(clk_out), .rst_out(rst_out), .locked(locked)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each channel schedules its next event edge number.
  bit        m_valid = 0;
  bit        m_run;
  int        m_low;
  int        m_n;
  int        m_d    [CH];
  bit        m_mode [CH];
  int        m_nxt  [CH];
  logic [CH-1:0] m_lvl, m_rst;
  logic      m_lock;
  bit        m_all, m_nm;
  logic      m_nl;

  always @(posedge clk) begin
    m_valid = 1;
    if (reset) begin
      m_run = 0; m_low = 0; m_n = -1;
      m_lvl = '0; m_rst = '1; m_lock = 0;
    end else if (!m_run) begin
      m_low++;
      if (m_low == FILT) begin m_run = 1; m_n = 0; end
    end else begin
      m_n++;
    end
    if (!m_run) begin
      for (int k = 0; k < CH; k++) begin
        m_d[k]    = int'(div_in[k*CW +: CW]);
        m_mode[k] = mode_in[k];
        m_nxt[k]  = m_d[k];
      end
    end else begin
      m_all = (m_rst == '0);
      for (int k = 0; k < CH; k++) begin
        if (m_n == m_nxt[k]) begin
          m_nm = mode_in[k];
          m_nl = (m_nm || m_mode[k]) ? 1'b1 : !m_lvl[k];
          if ((m_nm || (m_lvl[k] && !m_nl)) && m_n >= (1 << DB) + k * (1 << SB))
            m_rst[k] = 1'b0;
          m_lvl[k]  = m_nl;
          m_mode[k] = m_nm;
          m_d[k]    = int'(div_in[k*CW +: CW]);
          m_nxt[k]  = m_n + m_d[k] + 1;
        end else if (m_mode[k]) begin
          m_lvl[k] = 1'b0;
        end
      end
      if (m_all) m_lock = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (clk_out !== m_lvl || rst_out !== m_rst || locked !== m_lock) begin
        errors++;
        $display("FAIL model n=%0d clk_out=%b exp %b rst_out=%b exp %b locked=%b exp %b",
                 m_n, clk_out, m_lvl, rst_out, m_rst, locked, m_lock);
      end
    end
  end

  logic [CH-1:0] hist_clk [64];
  logic [CH-1:0] hist_rst [64];
  logic          hist_lck [64];
  int            hist_len;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [CH*CW-1:0] d, input logic [CH-1:0] m);
    reset   = 1'b1;
    div_in  = d;
    mode_in = m;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_state", int'({clk_out, rst_out, locked}), 5'b00110);
    end
    reset = 1'b0;
  endtask

  task automatic run(input int n, input int chg_at, input logic [CH*CW-1:0] chg_div);
    hist_len = n;
    for (int e = 0; e < n; e++) begin
      tick();
      hist_clk[e] = clk_out;
      hist_rst[e] = rst_out;
      hist_lck[e] = locked;
      if (e == chg_at) div_in = chg_div;
    end
  endtask

  function automatic int first_rst_low(input int ch);
    for (int e = 0; e < hist_len; e++) if (hist_rst[e][ch] == 1'b0) return e;
    return -1;
  endfunction

  function automatic int first_lock();
    for (int e = 0; e < hist_len; e++) if (hist_lck[e]) return e;
    return -1;
  endfunction

  task automatic check_stagger(input string tag);
    int r0, r1;
    r0 = first_rst_low(0);
    r1 = first_rst_low(1);
    chk({tag, "_rel0"}, r0, 23 + SH);
    chk({tag, "_rel1"}, r1, 27 + SH);
    chk({tag, "_lock"}, first_lock(), 28 + SH);
    if (r0 > 0) chk({tag, "_rel0_fall"}, int'({hist_clk[r0-1][0], hist_clk[r0][0]}), 2);
    if (r1 > 0) chk({tag, "_rel1_fall"}, int'({hist_clk[r1-1][1], hist_clk[r1][1]}), 2);
  endtask

  initial begin
    int ones;

    // Toggle clocks: ch0 D=3 (period 8), ch1 D=1 (period 4), staggered release.
    start({8'd1, 8'd3}, 2'b00);
    run(44, -1, '0);
    chk("ch0_rise3",  hist_clk[3+SH][0],  1);
    chk("ch0_high6",  hist_clk[6+SH][0],  1);
    chk("ch0_fall7",  hist_clk[7+SH][0],  0);
    chk("ch0_rise11", hist_clk[11+SH][0], 1);
    chk("ch1_rise1",  hist_clk[1+SH][1],  1);
    chk("ch1_fall3",  hist_clk[3+SH][1],  0);
    chk("ch1_rise5",  hist_clk[5+SH][1],  1);
    check_stagger("s2");

    // Strobe on ch0 with D=4, then D=0 becomes constant high.
    start({8'd1, 8'd4}, 2'b01);
    run(44, 16 + SH, {8'd1, 8'd0});
    chk("stb_4",  hist_clk[4+SH][0],  1);
    chk("stb_5",  hist_clk[5+SH][0],  0);
    chk("stb_8",  hist_clk[8+SH][0],  0);
    chk("stb_9",  hist_clk[9+SH][0],  1);
    chk("stb_14", hist_clk[14+SH][0], 1);
    chk("stb_18", hist_clk[18+SH][0], 0);
    ones = 0;
    for (int e = 19 + SH; e < 35 + SH; e++) ones += int'(hist_clk[e][0]);
    chk("stb_const1", ones, 16);
    chk("stb_rel0", first_rst_low(0), 19 + SH);
    chk("stb_rel1", first_rst_low(1), 27 + SH);

    // Ratio change 3->7 two cycles into a period.
    start({8'd1, 8'd3}, 2'b00);
    run(44, 9 + SH, {8'd1, 8'd7});
    chk("chg_10", hist_clk[10+SH][0], 0);
    chk("chg_11", hist_clk[11+SH][0], 1);
    chk("chg_18", hist_clk[18+SH][0], 1);
    chk("chg_19", hist_clk[19+SH][0], 0);
    chk("chg_26", hist_clk[26+SH][0], 0);
    chk("chg_27", hist_clk[27+SH][0], 1);
    chk("chg_rel0", first_rst_low(0), 19 + SH);

    // Reset pulse between the two channel releases restarts the sequence.
    start({8'd1, 8'd3}, 2'b00);
    run(25 + SH, -1, '0);
    chk("mid_rst_out", int'(hist_rst[24+SH]), 2'b10);
    reset = 1'b1;
    tick();
    chk("mid_reset", int'({clk_out, rst_out, locked}), 5'b00110);
    reset = 1'b0;
    run(44, -1, '0);
    check_stagger("restart");

`ifdef CLKRST_DEBOUNCE_EN
    // Short low window does not leave HOLD.
    start({8'd1, 8'd3}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("deb_short", int'(rst_out), 2'b11);
    end
    reset = 1'b1;
    tick();
    chk("deb_high", int'({clk_out, rst_out, locked}), 5'b00110);
    reset = 1'b0;
    run(44, -1, '0);
    check_stagger("deb");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
